// File: rtl/uart_pkg.sv
// Shared types and constants for the UART: receiver/transmitter state
// encodings and the clocks-per-bit computation.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Integer division: any remainder is dropped, so the line rate is
  // slightly above BAUD when FREQUENCY is not an exact multiple of it.
  function automatic int unsigned clks_per_bit(input int unsigned frequency,
                                               input int unsigned baud);
    return frequency / baud;
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Free-running baud-rate square wave: period CLKS_PER_BIT clocks, high for
// the first CLKS_PER_BIT/2 clocks of each period.
module uart_baud_div #(
  parameter int unsigned CLKS_PER_BIT = 1152
) (
  input  logic clk,
  input  logic res_n,
  output logic uart_clk
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CLKS_PER_BIT / 2);

  logic [CNT_W-1:0] cnt;

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt      <= '0;
      uart_clk <= 1'b0;
    end else begin
      cnt      <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      uart_clk <= (cnt < HALF_C);
    end
  end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: receive and transmit FSMs with independent bit-time
// counters, plus a baud-rate square wave from uart_baud_div.
module uart
  import uart_pkg::*;
#(
  parameter int unsigned FREQUENCY = 11059200,
  parameter int unsigned BAUD      = 9600
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       rx,
  output logic [0:7] rx_byte,
  output logic       rx_rdy,
  output logic       tx,
  output logic       tx_rdy,
  output logic       uart_clk,
  input  logic [0:7] tx_byte,
  input  logic       stb
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(FREQUENCY, BAUD);
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  uart_baud_div #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_div (
    .clk      (clk),
    .res_n    (res_n),
    .uart_clk (uart_clk)
  );

  // ---------------- receiver ----------------
  rx_state_t        rx_state, rx_state_nxt;
  logic [1:0]       rx_sync;
  logic             rx_s;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_byte_q;
  logic             rx_wait_high;
  logic             rx_tick;
  logic             rx_shift_en;
  logic             rx_done_ok;
  logic             rx_done_err;

  assign rx_s    = rx_sync[1];
  assign rx_byte = rx_byte_q;
  // The start bit is sampled at its middle; every later sample is one bit on.
  assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST)
                                          : (rx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      rx_state <= RX_IDLE;
    end else begin
      rx_state <= rx_state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    rx_state_nxt = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (!rx_wait_high && !rx_s) rx_state_nxt = RX_START;
      RX_START: if (rx_tick) rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_shift_en = 1'b0;
    rx_done_ok  = 1'b0;
    rx_done_err = 1'b0;
    unique case (rx_state)
      RX_DATA: rx_shift_en = rx_tick;
      RX_STOP: begin
        rx_done_ok  = rx_tick && rx_s;
        rx_done_err = rx_tick && !rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      rx_sync      <= 2'b11;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_byte_q    <= '0;
      rx_rdy       <= 1'b0;
      rx_wait_high <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_rdy  <= rx_done_ok;
      rx_cnt  <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + CNT_W'(1);
      if (rx_state == RX_IDLE) rx_bit <= '0;
      else if (rx_shift_en)    rx_bit <= rx_bit + 3'd1;
      if (rx_shift_en) rx_shift  <= {rx_s, rx_shift[7:1]};
      if (rx_done_ok)  rx_byte_q <= rx_shift;
      // After a framing error the line must return high before a new start.
      if (rx_done_err) rx_wait_high <= 1'b1;
      else if (rx_s)   rx_wait_high <= 1'b0;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t        tx_state, tx_state_nxt;
  logic             stb_q;
  logic             stb_rise;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_tick;
  logic             tx_load;
  logic             tx_shift_en;

  assign stb_rise = stb && !stb_q;
  assign tx_tick  = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_state_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (stb_rise) tx_state_nxt = TX_START;
      TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx          = 1'b1;
    tx_rdy      = 1'b0;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_rdy  = 1'b1;
        tx_load = stb_rise;
      end
      TX_START: tx = 1'b0;
      TX_DATA: begin
        tx          = tx_shift[0];
        tx_shift_en = tx_tick;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      stb_q    <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      stb_q  <= stb;
      tx_cnt <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + CNT_W'(1);
      if (tx_state == TX_IDLE) tx_bit <= '0;
      else if (tx_shift_en)    tx_bit <= tx_bit + 3'd1;
      if (tx_load)          tx_shift <= tx_byte;
      else if (tx_shift_en) tx_shift <= {1'b0, tx_shift[7:1]};
    end
  end

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart at default parameters: rx/tx scoreboards fed by the
// stimulus sequence, compared by monitors when the DUT produces output.
`timescale 1ns/1ps
module tb_uart;

  localparam int CPB  = 1152;
  localparam int HALF = 576;

  logic       clk     = 1'b0;
  logic       res_n   = 1'b0;
  logic       rx      = 1'b1;
  logic       stb_drv = 1'b0;
  logic       loop_en = 1'b0;
  logic       mon_en  = 1'b1;
  logic       in_stop = 1'b0;
  logic [0:7] byte_drv = '0;

  logic [0:7] rx_byte, tx_byte;
  logic       rx_rdy, tx, tx_rdy, uart_clk, stb;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  // Loopback routes the receiver straight into the transmitter.
  assign stb     = loop_en ? rx_rdy  : stb_drv;
  assign tx_byte = loop_en ? rx_byte : byte_drv;

  uart dut (
    .clk      (clk),
    .res_n    (res_n),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_rdy   (rx_rdy),
    .tx       (tx),
    .tx_rdy   (tx_rdy),
    .uart_clk (uart_clk),
    .tx_byte  (tx_byte),
    .stb      (stb)
  );

  always #45.211 clk = ~clk;

  initial begin
    #15_000_000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; a good stop bit queues the byte for the receiver (and
  // for the transmitter when looped back). The line is left at the stop level.
  task automatic send_rx(input logic [7:0] data, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_clks(CPB);
    end
    if (stop) begin
      rx_q.push_back(data);
      if (loop_en) tx_q.push_back(data);
    end
    in_stop = 1'b1;
    rx = stop;
    wait_clks(CPB);
    in_stop = 1'b0;
  endtask

  // Receive monitor.
  initial forever begin
    @(negedge clk);
    if (rx_rdy === 1'b1) begin : rx_mon
      logic [7:0] exp_b;
      if (rx_q.size() == 0) begin
        check("rx_unexpected_rdy", rx_rdy, 1'b0);
      end else begin
        exp_b = rx_q.pop_front();
        check("rx_byte", rx_byte, exp_b);
        check("rx_rdy_in_stop_bit", in_stop, 1'b1);
        @(negedge clk);
        check("rx_rdy_one_clk", rx_rdy, 1'b0);
      end
    end
  end

  // Transmit monitor: samples the first and last clock of each of 10 bits.
  initial forever begin
    @(negedge clk);
    if (mon_en && tx === 1'b0) begin : tx_mon
      logic [9:0] early, late, exp_f;
      logic [7:0] eb;
      for (int c = 0; c < 10 * CPB; c++) begin
        if (c % CPB == 0)       early[c / CPB] = tx;
        if (c % CPB == CPB - 1) late[c / CPB]  = tx;
        if (c != 10 * CPB - 1) @(negedge clk);
      end
      if (tx_q.size() == 0) begin
        check("tx_unexpected_frame", {22'd0, early}, 32'h3ff);
      end else begin
        eb    = tx_q.pop_front();
        exp_f = {1'b1, eb, 1'b0};
        check("tx_frame_bit_start", {22'd0, early}, {22'd0, exp_f});
        check("tx_frame_bit_end", {22'd0, late}, {22'd0, exp_f});
      end
    end
  end

  // tx_rdy busy-time monitor.
  initial forever begin
    @(negedge clk);
    if (mon_en && tx_rdy === 1'b0) begin : rdy_mon
      int n;
      n = 0;
      while (tx_rdy === 1'b0 && n < 30 * CPB) begin
        n++;
        @(negedge clk);
      end
      check("tx_rdy_low_clks", n, 10 * CPB);
    end
  end

  initial begin : stim
    int hi, per;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_tx_rdy", tx_rdy, 1'b1);
    check("reset_rx_rdy", rx_rdy, 1'b0);
    check("reset_rx_byte", rx_byte, 8'h00);
    check("reset_uart_clk", uart_clk, 1'b0);
    res_n = 1'b1;

    // uart_clk: first period after reset.
    hi = 0;
    while (uart_clk !== 1'b1 && hi < 4 * CPB) begin
      hi++;
      @(negedge clk);
    end
    hi = 0;
    while (uart_clk === 1'b1 && hi < 4 * CPB) begin
      hi++;
      @(negedge clk);
    end
    per = hi;
    while (uart_clk === 1'b0 && per < 4 * CPB) begin
      per++;
      @(negedge clk);
    end
    check("uart_clk_high_clks", hi, HALF);
    check("uart_clk_period_clks", per, CPB);

    // Receive 8C with loopback into the transmitter.
    loop_en = 1'b1;
    wait_clks(100);
    send_rx(8'h8C, 1'b1);
    wait_clks(600);
    check("rx_8c_received", rx_q.size(), 0);

    // Short low glitch rejected, then 55 received (and looped back).
    rx = 1'b0;
    wait_clks(300);
    rx = 1'b1;
    wait_clks(1500);
    send_rx(8'h55, 1'b1);
    wait_clks(600);
    check("rx_55_received", rx_q.size(), 0);
    check("rx_byte_after_55", rx_byte, 8'h55);

    // Framing error with the line held low afterwards.
    send_rx(8'hF0, 1'b0);
    wait_clks(1500);
    rx = 1'b1;
    wait_clks(600);
    check("rx_byte_after_framing_err", rx_byte, 8'h55);

    per = 0;
    while (tx_rdy !== 1'b1 && per < 30 * CPB) begin
      per++;
      @(negedge clk);
    end
    check("tx_idle_after_loopback", tx_rdy, 1'b1);
    wait_clks(100);
    check("tx_loopback_frames_sent", tx_q.size(), 0);

    // Manual transmit; a second stb edge mid-frame held high is ignored.
    loop_en  = 1'b0;
    byte_drv = 8'hA3;
    tx_q.push_back(8'hA3);
    stb_drv = 1'b1;
    wait_clks(3);
    stb_drv = 1'b0;
    wait_clks(4 * CPB);
    stb_drv = 1'b1;
    per = 0;
    while (tx_rdy !== 1'b1 && per < 30 * CPB) begin
      per++;
      @(negedge clk);
    end
    check("tx_idle_after_a3", tx_rdy, 1'b1);
    wait_clks(2 * CPB);
    check("tx_a3_sent", tx_q.size(), 0);
    check("no_extra_frame_tx", tx, 1'b1);
    check("no_extra_frame_rdy", tx_rdy, 1'b1);
    stb_drv = 1'b0;
    wait_clks(10);

    // Reset in the middle of a transmit frame.
    mon_en   = 1'b0;
    byte_drv = 8'h0F;
    stb_drv  = 1'b1;
    wait_clks(3 * CPB);
    check("tx_busy_before_abort", tx_rdy, 1'b0);
    res_n   = 1'b0;
    stb_drv = 1'b0;
    @(negedge clk);
    check("abort_tx", tx, 1'b1);
    check("abort_tx_rdy", tx_rdy, 1'b1);
    check("abort_rx_rdy", rx_rdy, 1'b0);
    check("abort_uart_clk", uart_clk, 1'b0);
    res_n = 1'b1;
    wait_clks(2 * CPB);
    check("post_abort_tx", tx, 1'b1);
    check("post_abort_tx_rdy", tx_rdy, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
